// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
//   DATA_W / REG_W : default datapath and register-index widths
//   alu_op_e       : opcode encoding understood by the alu block
//   stage_state_e  : occupancy of a one-entry pipeline register
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SLT = 4'd4,
    ALU_NOR = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector.
//   idx                         : architectural source register index
//   dflt                        : value used when no forward source hits
//   exm_wr_en/exm_rd/exm_data   : EX/MEM result (highest priority)
//   mwb_wr_en/mwb_rd/mwb_data   : MEM/WB result
//   result                      : selected operand value
// Register 0 is hard-wired to zero in MIPS, so it never takes a forward.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] dflt,
  input  logic              exm_wr_en,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wr_en,
  input  logic [REG_W-1:0]  mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = dflt;
    if (idx != '0) begin
      if (exm_wr_en && (exm_rd == idx)) begin
        result = exm_data;
      end else if (mwb_wr_en && (mwb_rd == idx)) begin
        result = mwb_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue register feeding the alu block from flops.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   flush                            : drop the held entry and any offered entry
//   dec_*                            : decoded instruction offer, dec_ready handshake
//   exm_* / mwb_*                    : EX/MEM and MEM/WB forwarding sources
//   ex_valid / ex_ready              : handshake toward execute
//   alu_opcode, alu_a, alu_b         : registered ALU inputs
//   ex_rd, ex_is_load                : destination index and load marker
// A held instruction keeps re-forwarding its register operands so that a
// result arriving during backpressure is not missed.
module alu_issue_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [3:0]        dec_alu_op,
  input  logic [REG_W-1:0]  dec_rs_idx,
  input  logic [REG_W-1:0]  dec_rt_idx,
  input  logic [REG_W-1:0]  dec_rd_idx,
  input  logic [DATA_W-1:0] dec_rs_val,
  input  logic [DATA_W-1:0] dec_rt_val,
  input  logic [15:0]       dec_imm,
  input  logic              dec_use_imm,
  input  logic              dec_sign_ext,
  input  logic              dec_shift,
  input  logic [4:0]        dec_shamt,
  input  logic              dec_is_load,
  input  logic              exm_wr_en,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wr_en,
  input  logic [REG_W-1:0]  mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_is_load
);

  import mips_pkg::*;

  stage_state_e      state_q, state_d;
  logic [3:0]        alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic              ex_is_load_q, ex_is_load_d;
  // Stored source indices and "operand came from a register" flags drive
  // the held-refresh forwarding.
  logic [REG_W-1:0]  rs_idx_q, rs_idx_d;
  logic [REG_W-1:0]  rt_idx_q, rt_idx_d;
  logic              a_is_reg_q, a_is_reg_d;
  logic              b_is_reg_q, b_is_reg_d;

  logic advance, hazard, capture;

  // Four forwarding lookups: 0 = decode rs, 1 = decode rt,
  // 2 = held A refresh, 3 = held B refresh.
  logic [REG_W-1:0]  fm_idx  [4];
  logic [DATA_W-1:0] fm_dflt [4];
  logic [DATA_W-1:0] fm_out  [4];

  assign fm_idx[0]  = dec_rs_idx;
  assign fm_dflt[0] = dec_rs_val;
  assign fm_idx[1]  = dec_rt_idx;
  assign fm_dflt[1] = dec_rt_val;
  assign fm_idx[2]  = rs_idx_q;
  assign fm_dflt[2] = alu_a_q;
  assign fm_idx[3]  = rt_idx_q;
  assign fm_dflt[3] = alu_b_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
      fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd (
        .idx       (fm_idx[gi]),
        .dflt      (fm_dflt[gi]),
        .exm_wr_en (exm_wr_en),
        .exm_rd    (exm_rd),
        .exm_data  (exm_data),
        .mwb_wr_en (mwb_wr_en),
        .mwb_rd    (mwb_rd),
        .mwb_data  (mwb_data),
        .result    (fm_out[gi])
      );
    end
  endgenerate

  assign ex_valid   = (state_q == ST_FULL);
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign ex_rd      = ex_rd_q;
  assign ex_is_load = ex_is_load_q;

  // A load in the stage has no data yet, so a consumer must wait one cycle
  // and pick the value up from a forward source instead.
  assign advance = !ex_valid || ex_ready;
  assign hazard  = dec_valid && ex_valid && ex_is_load_q && (ex_rd_q != '0) &&
                   ((ex_rd_q == dec_rs_idx) || ((ex_rd_q == dec_rt_idx) && !dec_use_imm));
  assign dec_ready = advance && !hazard && !flush;
  assign capture   = dec_valid && dec_ready;

  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    rs_idx_d     = rs_idx_q;
    rt_idx_d     = rt_idx_q;
    a_is_reg_d   = a_is_reg_q;
    b_is_reg_d   = b_is_reg_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else if (capture) begin
      state_d      = ST_FULL;
      alu_opcode_d = dec_alu_op;
      alu_a_d      = dec_shift ? {{(DATA_W-5){1'b0}}, dec_shamt} : fm_out[0];
      if (dec_use_imm) begin
        alu_b_d = dec_sign_ext ? {{(DATA_W-16){dec_imm[15]}}, dec_imm}
                               : {{(DATA_W-16){1'b0}}, dec_imm};
      end else begin
        alu_b_d = fm_out[1];
      end
      ex_rd_d      = dec_rd_idx;
      ex_is_load_d = dec_is_load;
      rs_idx_d     = dec_rs_idx;
      rt_idx_d     = dec_rt_idx;
      a_is_reg_d   = !dec_shift;
      b_is_reg_d   = !dec_use_imm;
    end else if (advance) begin
      // Covers both the load-use bubble and an idle decode slot.
      state_d = ST_EMPTY;
    end else begin
      // Held under backpressure: refresh register-sourced operands only.
      if (a_is_reg_q) alu_a_d = fm_out[2];
      if (b_is_reg_q) alu_b_d = fm_out[3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      alu_opcode_q <= 4'(ALU_AND);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      ex_rd_q      <= '0;
      ex_is_load_q <= 1'b0;
      rs_idx_q     <= '0;
      rt_idx_q     <= '0;
      a_is_reg_q   <= 1'b0;
      b_is_reg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
      rs_idx_q     <= rs_idx_d;
      rt_idx_q     <= rt_idx_d;
      a_is_reg_q   <= a_is_reg_d;
      b_is_reg_q   <= b_is_reg_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the issue register.
module tb_alu_issue_stage;

  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_alu_op;
  logic [4:0]  dec_rs_idx, dec_rt_idx, dec_rd_idx;
  logic [31:0] dec_rs_val, dec_rt_val;
  logic [15:0] dec_imm;
  logic        dec_use_imm, dec_sign_ext, dec_shift;
  logic [4:0]  dec_shamt;
  logic        dec_is_load;
  logic        exm_wr_en;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        mwb_wr_en;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  ex_rd;
  logic        ex_is_load;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_alu_op   (dec_alu_op),
    .dec_rs_idx   (dec_rs_idx),
    .dec_rt_idx   (dec_rt_idx),
    .dec_rd_idx   (dec_rd_idx),
    .dec_rs_val   (dec_rs_val),
    .dec_rt_val   (dec_rt_val),
    .dec_imm      (dec_imm),
    .dec_use_imm  (dec_use_imm),
    .dec_sign_ext (dec_sign_ext),
    .dec_shift    (dec_shift),
    .dec_shamt    (dec_shamt),
    .dec_is_load  (dec_is_load),
    .exm_wr_en    (exm_wr_en),
    .exm_rd       (exm_rd),
    .exm_data     (exm_data),
    .mwb_wr_en    (mwb_wr_en),
    .mwb_rd       (mwb_rd),
    .mwb_data     (mwb_data),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load)
  );

  // ---------------- reference model ----------------
  // The held instruction; a source of -1 marks an operand that did not come
  // from a register (immediate or shamt) and therefore is never refreshed.
  bit          m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  int          m_rd;
  bit          m_load;
  int          m_a_src, m_b_src;

  task automatic model_reset();
    m_valid = 0; m_op = '0; m_a = '0; m_b = '0;
    m_rd = 0; m_load = 0; m_a_src = -1; m_b_src = -1;
  endtask

  // Newest producer wins; r0 is always zero-valued and never forwarded.
  function automatic logic [31:0] reg_value(input int r, input logic [31:0] fallback);
    if (r == 0) return fallback;
    if (exm_wr_en && int'(exm_rd) == r) return exm_data;
    if (mwb_wr_en && int'(mwb_rd) == r) return mwb_data;
    return fallback;
  endfunction

  function automatic bit model_ready();
    bit adv, haz;
    adv = !m_valid || ex_ready;
    haz = dec_valid && m_valid && m_load && (m_rd != 0) &&
          (m_rd == int'(dec_rs_idx) || (m_rd == int'(dec_rt_idx) && !dec_use_imm));
    return adv && !haz && !flush;
  endfunction

  task automatic model_edge();
    bit rdy;
    rdy = model_ready();
    if (flush) begin
      m_valid = 0;
    end else if (dec_valid && rdy) begin
      m_valid = 1;
      m_op    = dec_alu_op;
      if (dec_shift) begin
        m_a = 32'(dec_shamt);
        m_a_src = -1;
      end else begin
        m_a = reg_value(int'(dec_rs_idx), dec_rs_val);
        m_a_src = int'(dec_rs_idx);
      end
      if (dec_use_imm) begin
        m_b = dec_sign_ext ? 32'(int'(signed'(dec_imm))) : 32'(dec_imm);
        m_b_src = -1;
      end else begin
        m_b = reg_value(int'(dec_rt_idx), dec_rt_val);
        m_b_src = int'(dec_rt_idx);
      end
      m_rd   = int'(dec_rd_idx);
      m_load = dec_is_load;
      $display("[%0d] issue op=%0d a=%h b=%h rd=%0d load=%0b", cyc, m_op, m_a, m_b, m_rd, m_load);
    end else if (!m_valid || ex_ready) begin
      m_valid = 0;
    end else begin
      if (m_a_src >= 0) m_a = reg_value(m_a_src, m_a);
      if (m_b_src >= 0) m_b = reg_value(m_b_src, m_b);
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check_eq("ex_valid", 32'(ex_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("alu_opcode", 32'(alu_opcode), 32'(m_op));
      check_eq("alu_a", alu_a, m_a);
      check_eq("alu_b", alu_b, m_b);
      check_eq("ex_rd", 32'(ex_rd), 32'(m_rd));
      check_eq("ex_is_load", 32'(ex_is_load), 32'(m_load));
    end
  endtask

  // One clock: inputs already driven; check handshake, clock, check outputs.
  task automatic step();
    #1;
    check_eq("dec_ready", 32'(dec_ready), 32'(model_ready()));
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic clear_fwd();
    exm_wr_en = 0; exm_rd = '0; exm_data = '0;
    mwb_wr_en = 0; mwb_rd = '0; mwb_data = '0;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv);
    dec_valid = 1; dec_alu_op = op;
    dec_rs_idx = rs; dec_rt_idx = rt; dec_rd_idx = rd;
    dec_rs_val = rsv; dec_rt_val = rtv;
    dec_imm = '0; dec_use_imm = 0; dec_sign_ext = 0;
    dec_shift = 0; dec_shamt = '0; dec_is_load = 0;
  endtask

  initial begin
    rst_n = 1; flush = 0; ex_ready = 1;
    set_instr(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    dec_valid = 0;
    clear_fwd();
    model_reset();
    #1 rst_n = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_opcode", 32'(alu_opcode), 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_ex_rd", 32'(ex_rd), 32'd0);
    check_eq("rst_is_load", 32'(ex_is_load), 32'd0);
    rst_n = 1;
    #1 check_eq("rst_dec_ready", 32'(dec_ready), 32'd1);

    // Basic ADD
    set_instr(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd101010101, 32'd11);
    step();
    check_eq("add_valid", 32'(ex_valid), 32'd1);
    check_eq("add_op", 32'(alu_opcode), 32'd2);
    check_eq("add_a", alu_a, 32'd101010101);
    check_eq("add_b", alu_b, 32'd11);

    // Forwarding priority
    set_instr(ALU_ADD, 5'd5, 5'd2, 5'd3, 32'h1111, 32'd0);
    exm_wr_en = 1; exm_rd = 5'd5; exm_data = 32'd7;
    mwb_wr_en = 1; mwb_rd = 5'd5; mwb_data = 32'd9;
    step();
    check_eq("fwd_exm", alu_a, 32'd7);
    exm_wr_en = 0;
    step();
    check_eq("fwd_mwb", alu_a, 32'd9);
    dec_rs_idx = 5'd0; exm_wr_en = 1; exm_rd = 5'd0; mwb_rd = 5'd0;
    step();
    check_eq("fwd_r0", alu_a, 32'h1111);
    clear_fwd();

    // Immediates and shift amount
    set_instr(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5);
    dec_imm = 16'hFFFE; dec_use_imm = 1; dec_sign_ext = 1;
    step();
    check_eq("imm_sext", alu_b, 32'hFFFFFFFE);
    dec_sign_ext = 0;
    step();
    check_eq("imm_zext", alu_b, 32'h0000FFFE);
    set_instr(ALU_SLL, 5'd0, 5'd2, 5'd3, 32'd0, 32'd5);
    dec_shift = 1; dec_shamt = 5'd3;
    step();
    check_eq("sll_a", alu_a, 32'd3);
    check_eq("sll_op", 32'(alu_opcode), 32'd7);

    // Load-use: one bubble, then capture with the loaded value forwarded
    set_instr(ALU_ADD, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0);
    dec_is_load = 1;
    step();
    set_instr(ALU_ADD, 5'd8, 5'd2, 5'd9, 32'hDEAD, 32'd1);
    #1 check_eq("lu_ready", 32'(dec_ready), 32'd0);
    step();
    check_eq("lu_bubble", 32'(ex_valid), 32'd0);
    mwb_wr_en = 1; mwb_rd = 5'd8; mwb_data = 32'h1234;
    step();
    check_eq("lu_valid", 32'(ex_valid), 32'd1);
    check_eq("lu_a", alu_a, 32'h1234);
    clear_fwd();

    // Backpressure with refresh of the held rt operand
    set_instr(ALU_OR, 5'd1, 5'd6, 5'd4, 32'd0, 32'd5);
    step();
    ex_ready = 0;
    set_instr(ALU_XOR, 5'd2, 5'd3, 5'd5, 32'h77, 32'h88);
    #1 check_eq("bp_ready1", 32'(dec_ready), 32'd0);
    step();
    check_eq("bp_b1", alu_b, 32'd5);
    mwb_wr_en = 1; mwb_rd = 5'd6; mwb_data = 32'd42;
    #1 check_eq("bp_ready2", 32'(dec_ready), 32'd0);
    step();
    check_eq("bp_b2", alu_b, 32'd42);
    clear_fwd();
    #1 check_eq("bp_ready3", 32'(dec_ready), 32'd0);
    step();
    check_eq("bp_b3", alu_b, 32'd42);
    check_eq("bp_op_held", 32'(alu_opcode), 32'd1);
    ex_ready = 1;
    step();
    check_eq("bp_next_op", 32'(alu_opcode), 32'd6);
    check_eq("bp_next_a", alu_a, 32'h77);

    // Flush with an offered instruction while FULL
    flush = 1;
    set_instr(ALU_SUB, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9);
    #1 check_eq("flush_ready", 32'(dec_ready), 32'd0);
    step();
    check_eq("flush_valid", 32'(ex_valid), 32'd0);
    flush = 0;

    // Asynchronous reset in the middle of a cycle
    step();
    #2 rst_n = 0;
    #1;
    check_eq("arst_valid", 32'(ex_valid), 32'd0);
    check_eq("arst_a", alu_a, 32'd0);
    check_eq("arst_b", alu_b, 32'd0);
    check_eq("arst_op", 32'(alu_opcode), 32'd0);
    check_eq("arst_rd", 32'(ex_rd), 32'd0);
    rst_n = 1;
    model_reset();
    step();

    // Random traffic; small index range keeps hazards and forwards frequent
    for (int i = 0; i < 1500; i++) begin
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_alu_op   = 4'($urandom_range(0, 8));
      dec_rs_idx   = 5'($urandom_range(0, 3));
      dec_rt_idx   = 5'($urandom_range(0, 3));
      dec_rd_idx   = 5'($urandom_range(0, 3));
      dec_rs_val   = $urandom;
      dec_rt_val   = $urandom;
      dec_imm      = 16'($urandom);
      dec_use_imm  = ($urandom_range(0, 3) == 0);
      dec_sign_ext = 1'($urandom);
      dec_shift    = ($urandom_range(0, 5) == 0);
      dec_shamt    = 5'($urandom);
      dec_is_load  = ($urandom_range(0, 2) == 0);
      exm_wr_en    = 1'($urandom);
      exm_rd       = 5'($urandom_range(0, 3));
      exm_data     = $urandom;
      mwb_wr_en    = 1'($urandom);
      mwb_rd       = 5'($urandom_range(0, 3));
      mwb_data     = $urandom;
      ex_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      step();
    end

    dec_valid = 0; flush = 0; ex_ready = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue register for the MIPS core, feeding the `alu` block directly. It captures one decoded instruction per cycle and resolves operand forwarding from EX/MEM and MEM/WB. It selects the immediate or shift amount, detects load-use hazards and holds the instruction under downstream backpressure. Its outputs drive `alu.opcode`, `alu.a` and `alu.b` straight from flops.

## Interface
Parameters:
- `DATA_W`, 32, operand width.
- `REG_W`, 5, register index width.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `flush`  in  1  kill held entry and any entry offered this cycle
- `dec_valid`  in  1  decode offers an instruction
- `dec_ready`  out  1  stage accepts this cycle
- `dec_alu_op`  in  4  ALU opcode
- `dec_rs_idx`, `dec_rt_idx`, `dec_rd_idx`  in  REG_W  source/dest indices
- `dec_rs_val`, `dec_rt_val`  in  DATA_W  register-file values
- `dec_imm`  in  16  immediate
- `dec_use_imm`  in  1  B operand is immediate
- `dec_sign_ext`  in  1  sign-extend immediate (else zero-extend)
- `dec_shift`  in  1  A operand is `dec_shamt`
- `dec_shamt`  in  5  shift amount
- `dec_is_load`  in  1  instruction is a load
- `exm_wr_en`, `exm_rd`, `exm_data`  in  1/REG_W/DATA_W  EX/MEM forward source
- `mwb_wr_en`, `mwb_rd`, `mwb_data`  in  1/REG_W/DATA_W  MEM/WB forward source
- `ex_valid`  out  1  ALU inputs hold a live instruction
- `ex_ready`  in  1  execute consumes this cycle
- `alu_opcode`  out  4  to `alu.opcode`
- `alu_a`, `alu_b`  out  DATA_W  to `alu.a`, `alu.b`
- `ex_rd`  out  REG_W  destination index
- `ex_is_load`  out  1  load marker

## Operation
- One-entry register with state EMPTY (`ex_valid`=0) or FULL (`ex_valid`=1).
- `advance = !ex_valid | ex_ready`.
- `hazard = dec_valid & ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==dec_rs_idx | (ex_rd==dec_rt_idx & !dec_use_imm))`.
- `dec_ready = advance & !hazard & !flush`. This is combinational.
- Capture occurs when `dec_valid & dec_ready`. The stage loads the op, operands, indices, `ex_rd` and `ex_is_load`, and `ex_valid` becomes 1.
- `hazard & advance` inserts a bubble: `ex_valid` becomes 0 and the decode entry stays offered.
- `advance & !dec_valid` moves the stage to EMPTY.
- `flush` takes priority over everything: `ex_valid` becomes 0 at the next edge and nothing is captured.
- Forwarding applies per source, index 0 never forwards. Priority is EX/MEM hit (`exm_wr_en & exm_rd==idx`), then MEM/WB hit, then `dec_*_val`.
- A operand:
  - `dec_shift`: `{27'b0, dec_shamt}`.
  - Otherwise: forwarded rs.
- B operand:
  - `dec_use_imm`: `{{16{imm[15]}},imm}` if `dec_sign_ext`, else `{16'b0,imm}`.
  - Otherwise: forwarded rt.
- Held refresh: while FULL and `!ex_ready`, the stage re-applies forwarding to each held register-sourced operand every cycle, using the stored rs/rt indices. Immediate and shamt operands are never refreshed.
- Opcode encoding (`alu`): 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 XOR, 7 SLL, 8 SRL. This stage passes the opcode through without interpretation.

## Timing
- Reset values: `ex_valid`=0, `alu_opcode`=0, `alu_a`=0, `alu_b`=0, `ex_rd`=0, `ex_is_load`=0, internal indices and source flags 0.
- `dec_ready` is 1 out of reset, absent `flush`.
- Latency is 1 cycle from the accepting edge to valid ALU inputs. Throughput is 1 per cycle when `ex_ready`=1.
- A load followed by a dependent instruction gives exactly one bubble cycle, then the dependent instruction is captured with the loaded value via EX/MEM or MEM/WB.
- Outputs are stable while FULL and `!ex_ready`, except for operand refresh.
- Simultaneous `flush` and `dec_valid`: the decode entry is dropped and `dec_ready`=0.
- Reset asserted mid-operation clears the entry immediately, asynchronously.

## Structure
- Shared package `mips_pkg`: ALU opcode constants (`ALU_AND`..`ALU_SRL`), `DATA_W`, `REG_W`.
- One sub-module, `fwd_mux`, instantiated twice (rs, rt) plus twice for held refresh. It takes an index, a default value and both forward sources, and returns the selected value.

## Test plan
- Reset, then ADD with rs_val=101010101, rt_val=11, no forwards → next cycle `alu_opcode`=2, `alu_a`=101010101, `alu_b`=11, `ex_valid`=1.
- Forward priority: rs=5 with `exm_rd`=5 data=7 and `mwb_rd`=5 data=9 → `alu_a`=7. With only MEM/WB hitting → `alu_a`=9. With rs=0 and both hitting → `alu_a`=rs_val.
- Immediate handling:
  - imm=16'hFFFE, use_imm, sign_ext → `alu_b`=32'hFFFFFFFE.
  - Same without sign_ext → 32'h0000FFFE.
  - SLL with shamt=3 → `alu_a`=3.
- Load-use: load to r8 held in the stage, then dependent rs=8 offered → one cycle with `dec_ready`=0 and `ex_valid`=0, then capture on the following cycle.
- Backpressure: `ex_ready`=0 for 3 cycles with `mwb_rd` matching held rt and data=42 on cycle 2 → `alu_b`=42 from cycle 3, `dec_ready`=0 throughout, no entry lost.
- `flush` with `dec_valid`=1 while FULL → next cycle `ex_valid`=0. `rst_n` pulsed low mid-stream → outputs clear immediately.
